ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
Instruction fetch front-end for the SISC multi-cycle core. It sits between the instruction memory and the instruction register / control path.
- Runs its own fetch PC and issues word reads over a req/ack handshake.
- Buffers returned instructions, tagged with their address, in a small FIFO.
- Presents the FIFO head to the IR with valid/ready.
- A redirect input (taken branch or jump from ctrl/br) flushes the queue and restarts fetch at a new address.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, 2..16)
ADDR_W, 16, instruction address width (word address)
DATA_W, 32, instruction width

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_f  in  1  synchronous active-low reset
mem_req  out  1  fetch request to instruction memory
mem_addr  out  ADDR_W  fetch word address; held stable while mem_req=1
mem_ack  in  1  memory has returned data this cycle; ignored when mem_req=0
mem_rdata  in  DATA_W  instruction data, valid when mem_req&mem_ack
instr  out  DATA_W  FIFO head instruction
instr_pc  out  ADDR_W  address of FIFO head instruction
instr_valid  out  1  FIFO not empty
instr_ready  in  1  consumer (ir_load) takes head this cycle
redirect  in  1  flush queue and restart fetch
redirect_addr  in  ADDR_W  new fetch address, sampled when redirect=1
fill_level  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_f=0 at a clock edge):
  - state=IDLE, fpc=0, FIFO empty.
  - mem_req=0, mem_addr=0, instr_valid=0, fill_level=0.
  - instr and instr_pc are don't-care but driven (0 after reset).
  - Reset overrides everything, including mid-transaction; any in-flight ack is dropped.
- State register outputs: mem_req = (state==REQ || state==DISCARD).
  - mem_addr is a registered copy of the request address.
  - In REQ that address is fpc. In DISCARD it is the stale address.
- FSM states: IDLE, REQ, DISCARD.
  - IDLE:
    - redirect=1: fpc<=redirect_addr, flush, stay IDLE.
    - Otherwise, if count_next<DEPTH: go to REQ with mem_addr<=fpc.
  - REQ, mem_ack=0:
    - redirect=1: flush, fpc<=redirect_addr, go to DISCARD. mem_addr is held, since the request may not be withdrawn.
    - Otherwise hold.
  - REQ, mem_ack=1:
    - redirect=1: data is dropped, flush, fpc<=redirect_addr, go to IDLE.
    - Otherwise: push {fpc, mem_rdata} and set fpc<=fpc+1.
    - Then, if count_next<DEPTH: stay in REQ with mem_addr<=fpc+1 (back-to-back fetch).
    - Else go to IDLE.
  - DISCARD:
    - Hold mem_req/mem_addr until mem_ack, then drop the data and go to IDLE.
    - A further redirect in DISCARD only updates fpc.
- count_next = count + push − pop, evaluated in the same cycle.
- At most one request is outstanding. A push never occurs when count==DEPTH, because issue is gated on space.
- Pop: instr_valid & instr_ready & !redirect.
  - Simultaneous push and pop leaves count unchanged.
  - A pop when empty is ignored.
- Redirect has priority over push and pop in the same cycle. After the edge the FIFO is empty and instr_valid=0.
- Outputs:
  - instr/instr_pc/instr_valid come directly from FIFO registers, with no combinational path from mem_* inputs.
  - instr_ready→pop has no effect on outputs until the next edge.
- Address arithmetic is modulo 2^ADDR_W: fpc wraps from 0xFFFF to 0x0000 silently.
- Latency, with zero-wait memory (ack in the cycle req is seen):
  - mem_req rises 1 cycle after rst_f goes high.
  - First instr_valid comes 1 cycle after that ack.
  - Sustained throughput is one instruction per cycle while the consumer pops every cycle.

Test Plan:
1. Reset, then zero-wait memory returning mem_rdata=0xA0000000+addr, instr_ready=1 → mem_req high at cycle 1; instr_valid from cycle 2; instr_pc streams 0,1,2,3…; instr=0xA0000000,0xA0000001,… with no gaps.
2. instr_ready=0, zero-wait memory → fill_level climbs 1,2,3,4; mem_req low once 4 are buffered. Then raise instr_ready for one cycle → exactly one new fetch issues; fill_level returns to 4; order is preserved.
3. Memory with 3-cycle ack delay; redirect to 0x0040 one cycle after req at addr 0x0002 → mem_addr holds 0x0002 until ack; that data is never visible. Next request addr=0x0040; first instr_pc=0x0040.
4. Redirect to 0x0100 in the same cycle as mem_ack and instr_ready=1 with 2 entries queued → fill_level=0 next cycle, no pop or push counted, next mem_addr=0x0100.
5. Redirect to 0xFFFE, zero-wait memory → instr_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
6. rst_f driven low for one cycle while in DISCARD with a full FIFO → next cycle mem_req=0, fill_level=0, instr_valid=0. After release, fetch restarts at addr 0x0000.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: runs the fetch PC, issues word reads over req/ack,
// and buffers returned instructions with their addresses for the IR.
module ifetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst_f,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [DATA_W-1:0]            instr,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_addr,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

    // state   | meaning
    // IDLE    | no request outstanding; issue when the queue has room
    // REQ     | request at fpc outstanding; data is pushed on ack
    // DISCARD | request outstanding but redirected away; data dropped on ack

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fpc;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [ADDR_W-1:0]   r_pc   [DEPTH];
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;

    logic                w_push;
    logic                w_pop;
    logic [CW-1:0]       w_count_next;
    logic                w_space;

    assign w_pop        = (r_count != '0) && instr_ready && !redirect;
    assign w_push       = (r_state == S_REQ) && mem_ack && !redirect;
    assign w_count_next = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    assign w_space      = (w_count_next < FULL);

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_pc[i]   <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= mem_rdata;
                r_pc[r_wptr]   <= r_fpc;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_state    <= S_IDLE;
            r_fpc      <= '0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect) begin
                        r_fpc <= redirect_addr;
                    end else if (w_space) begin
                        r_state    <= S_REQ;
                        r_mem_addr <= r_fpc;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (redirect) begin
                            r_fpc   <= redirect_addr;
                            r_state <= S_IDLE;
                        end else begin
                            r_fpc <= r_fpc + ADDR_W'(1);
                            if (w_space) begin
                                r_mem_addr <= r_fpc + ADDR_W'(1);
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end else if (redirect) begin
                        // the request cannot be withdrawn, so mem_addr stays put
                        r_fpc   <= redirect_addr;
                        r_state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (redirect) begin
                        r_fpc <= redirect_addr;
                    end
                    if (mem_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req     = (r_state == S_REQ) || (r_state == S_DISCARD);
    assign mem_addr    = r_mem_addr;
    assign instr       = r_data[r_rptr];
    assign instr_pc    = r_pc[r_rptr];
    assign instr_valid = (r_count != '0);
    assign fill_level  = r_count;

endmodule
